otter_branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the pipelined OTTER CPU. It replaces static "predict not-taken, flush on taken" fetch with a BTB (branch target buffer) plus 2-bit saturating counters. Bimodal or gshare indexing is selectable. Fetch queries it combinationally each cycle with the current PC. Execute reports every resolved branch/JAL back to it. It also produces the mispredict/redirect signal and performance counters.

---
 rtl/otter_branch_predictor.sv | 131 +++++++++++++
 tb/tb_otter_branch_predictor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_branch_predictor.sv
// BTB plus 2-bit saturating-counter branch predictor for the pipelined OTTER CPU.
// Fetch lookup and mispredict detection are combinational; training happens on the EX update edge.
module otter_branch_predictor #(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned TAG_BITS = 10,
    parameter int unsigned MODE     = 0,
    parameter int unsigned GHR_BITS = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_if_pc,
    input  logic        i_if_valid,
    output logic        o_pred_hit,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_next_pc,
    input  logic        i_ex_update,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_is_branch,
    input  logic        i_ex_is_jal,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_next_pc,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_count,
    output logic [31:0] o_miss_count
);
    localparam int unsigned IDX = $clog2(ENTRIES);

    logic [ENTRIES-1:0]  r_valid;
    logic [ENTRIES-1:0]  r_is_jal;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];
    logic [GHR_BITS-1:0] r_ghr;
    logic [31:0]         r_br_count;
    logic [31:0]         r_miss_count;

    logic [IDX-1:0]      w_ghr_idx;
    logic [IDX-1:0]      w_if_bidx;
    logic [IDX-1:0]      w_if_cidx;
    logic [TAG_BITS-1:0] w_if_tag;
    logic [IDX-1:0]      w_ex_bidx;
    logic [IDX-1:0]      w_ex_cidx;
    logic [TAG_BITS-1:0] w_ex_tag;
    logic                w_hit;
    logic                w_mispredict;
    logic                w_btb_wr;
    logic                w_ctr_wr;
    logic [1:0]          w_ctr_cur;
    logic [1:0]          w_ctr_next;
    logic                w_unused;

    // gshare folds the history into the low index bits; bimodal ignores it
    assign w_ghr_idx = (MODE == 1) ? IDX'(r_ghr) : '0;

    assign w_if_bidx = i_if_pc[IDX+1:2];
    assign w_if_tag  = i_if_pc[IDX+2 +: TAG_BITS];
    assign w_if_cidx = w_if_bidx ^ w_ghr_idx;
    assign w_ex_bidx = i_ex_pc[IDX+1:2];
    assign w_ex_tag  = i_ex_pc[IDX+2 +: TAG_BITS];
    assign w_ex_cidx = w_ex_bidx ^ w_ghr_idx;

    // Fetch-side lookup from registered state only
    assign w_hit          = r_valid[w_if_bidx] & (r_tag[w_if_bidx] == w_if_tag);
    assign o_pred_hit     = w_hit;
    assign o_pred_taken   = i_if_valid & w_hit & (r_is_jal[w_if_bidx] | r_ctr[w_if_cidx][1]);
    assign o_pred_next_pc = o_pred_taken ? r_target[w_if_bidx] : i_if_pc + 32'd4;

    // Execute-side resolution
    assign w_mispredict  = i_ex_update & ((i_ex_taken != i_ex_pred_taken) |
                                          (i_ex_taken & (i_ex_pred_next_pc != i_ex_target)));
    assign o_mispredict  = w_mispredict;
    assign o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc + 32'd4;
    assign w_btb_wr      = i_ex_update & ((i_ex_is_branch & i_ex_taken) | i_ex_is_jal);
    assign w_ctr_wr      = i_ex_update & i_ex_is_branch;

    assign o_br_count    = r_br_count;
    assign o_miss_count  = r_miss_count;

    always_comb begin
        w_ctr_cur  = r_ctr[w_ex_cidx];
        w_ctr_next = w_ctr_cur;
        if (i_ex_taken && (w_ctr_cur != 2'b11)) begin
            w_ctr_next = w_ctr_cur + 2'd1;
        end else if (!i_ex_taken && (w_ctr_cur != 2'b00)) begin
            w_ctr_next = w_ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid      <= '0;
            r_ghr        <= '0;
            r_br_count   <= '0;
            r_miss_count <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else begin
            if (w_btb_wr) begin
                r_valid[w_ex_bidx] <= 1'b1;
            end
            if (w_ctr_wr) begin
                r_ctr[w_ex_cidx] <= w_ctr_next;
                if (MODE == 1) begin
                    r_ghr <= GHR_BITS'({r_ghr, i_ex_taken});
                end
            end
            if (i_ex_update) begin
                r_br_count <= r_br_count + 32'd1;
                if (w_mispredict) begin
                    r_miss_count <= r_miss_count + 32'd1;
                end
            end
        end
    end

    // Payload is meaningless until the matching valid bit is set, so it needs no reset
    always_ff @(posedge i_clk) begin
        if (w_btb_wr) begin
            r_tag[w_ex_bidx]    <= w_ex_tag;
            r_target[w_ex_bidx] <= i_ex_target;
            r_is_jal[w_ex_bidx] <= i_ex_is_jal;
        end
    end

    assign w_unused = ^{i_if_pc, i_ex_pc, r_ghr};

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Bench for otter_branch_predictor: directed table, gshare and reset sequences, randomized run
// against an arithmetic reference model of the BTB, counters and history.
module tb_otter_branch_predictor;
    localparam int unsigned ENT  = 64;
    localparam int unsigned TAGB = 10;

    logic        clk, rst;
    logic [31:0] if_pc, ex_pc, ex_target, ex_pred_next_pc;
    logic        if_valid, ex_update, ex_is_branch, ex_is_jal, ex_taken, ex_pred_taken;

    logic        hit0, tk0, mis0, hit1, tk1, mis1;
    logic [31:0] nx0, rd0, br0, ms0, nx1, rd1, br1, ms1;

    int n_cmp = 0;
    int n_err = 0;

    otter_branch_predictor #(.ENTRIES(ENT), .TAG_BITS(TAGB), .MODE(0), .GHR_BITS(6)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_if_pc(if_pc), .i_if_valid(if_valid),
        .o_pred_hit(hit0), .o_pred_taken(tk0), .o_pred_next_pc(nx0),
        .i_ex_update(ex_update), .i_ex_pc(ex_pc), .i_ex_is_branch(ex_is_branch),
        .i_ex_is_jal(ex_is_jal), .i_ex_taken(ex_taken), .i_ex_target(ex_target),
        .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_next_pc(ex_pred_next_pc),
        .o_mispredict(mis0), .o_redirect_pc(rd0), .o_br_count(br0), .o_miss_count(ms0)
    );

    otter_branch_predictor #(.ENTRIES(ENT), .TAG_BITS(TAGB), .MODE(1), .GHR_BITS(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_if_pc(if_pc), .i_if_valid(if_valid),
        .o_pred_hit(hit1), .o_pred_taken(tk1), .o_pred_next_pc(nx1),
        .i_ex_update(ex_update), .i_ex_pc(ex_pc), .i_ex_is_branch(ex_is_branch),
        .i_ex_is_jal(ex_is_jal), .i_ex_taken(ex_taken), .i_ex_target(ex_target),
        .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_next_pc(ex_pred_next_pc),
        .o_mispredict(mis1), .o_redirect_pc(rd1), .o_br_count(br1), .o_miss_count(ms1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] if_pc;
        logic        if_valid;
        logic        upd;
        logic [31:0] ex_pc;
        logic        br;
        logic        jal;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] pnx;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_nx;
        logic        e_mis;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[16];

    // Reference model: plain arrays indexed by PC arithmetic; ctr[0] bimodal, ctr[1] gshare
    int unsigned m_valid[ENT], m_tag[ENT], m_tgt[ENT], m_jal[ENT];
    int unsigned m_ctr[2][ENT];
    int unsigned m_ghr, m_br, m_miss;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < int'(ENT); i++) begin
            m_valid[i] = 0;
            m_ctr[0][i] = 1;
            m_ctr[1][i] = 1;
        end
        m_ghr = 0; m_br = 0; m_miss = 0;
    endfunction

    function automatic void m_lookup(input int md, output logic hit, output logic tk,
                                     output logic [31:0] nx);
        int unsigned b, t, c;
        b = (if_pc >> 2) % ENT;
        t = (if_pc >> 8) % (1 << TAGB);
        c = (md == 1) ? (b ^ m_ghr) : b;
        hit = (m_valid[b] == 1) && (m_tag[b] == t);
        tk = if_valid && hit && ((m_jal[b] == 1) || (m_ctr[md][c] >= 2));
        nx = tk ? m_tgt[b] : if_pc + 32'd4;
    endfunction

    function automatic logic m_mispredict();
        return ex_update && ((ex_taken != ex_pred_taken) || (ex_taken && (ex_pred_next_pc != ex_target)));
    endfunction

    function automatic void m_update();
        int unsigned b, t, c;
        if (!ex_update) return;
        b = (ex_pc >> 2) % ENT;
        t = (ex_pc >> 8) % (1 << TAGB);
        m_br++;
        if (m_mispredict()) m_miss++;
        if (ex_is_branch) begin
            for (int md = 0; md < 2; md++) begin
                c = (md == 1) ? (b ^ m_ghr) : b;
                if (ex_taken && m_ctr[md][c] < 3) m_ctr[md][c]++;
                else if (!ex_taken && m_ctr[md][c] > 0) m_ctr[md][c]--;
            end
            m_ghr = ((m_ghr << 1) | (ex_taken ? 1 : 0)) % 4;
        end
        if ((ex_is_branch && ex_taken) || ex_is_jal) begin
            m_valid[b] = 1; m_tag[b] = t; m_tgt[b] = ex_target; m_jal[b] = ex_is_jal ? 1 : 0;
        end
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
        return p;
    endfunction

    task automatic set_ex(input logic upd, input logic [31:0] pc, input logic br, input logic jal,
                          input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] pnx);
        ex_update = upd; ex_pc = pc; ex_is_branch = br; ex_is_jal = jal;
        ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_next_pc = pnx;
    endtask

    task automatic do_reset();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic hx, tx, mx;
        logic [31:0] nx;
        logic [31:0] ghr_m;
        logic tk_g;
        int unsigned kind;

        // if_pc, if_valid, upd, ex_pc, br, jal, tk, tgt, ptk, pnx | hit, taken, next, mispredict, redirect
        tbl[0]  = '{32'h100, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h104, 1'b0, 32'h004};
        tbl[1]  = '{32'h040, 1'b1, 1'b1, 32'h040, 1'b1, 1'b0, 1'b1, 32'h020, 1'b0, 32'h044, 1'b0, 1'b0, 32'h044, 1'b1, 32'h020};
        tbl[2]  = '{32'h040, 1'b1, 1'b1, 32'h040, 1'b1, 1'b0, 1'b1, 32'h020, 1'b1, 32'h020, 1'b1, 1'b1, 32'h020, 1'b0, 32'h020};
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = '{32'h040, 1'b1, 1'b1, 32'h040, 1'b1, 1'b0, 1'b0, 32'h020, 1'b1, 32'h020, 1'b1, 1'b1, 32'h020, 1'b1, 32'h044};
        tbl[6]  = tbl[5];
        tbl[7]  = '{32'h040, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1, 1'b0, 32'h044, 1'b0, 32'h004};
        tbl[8]  = '{32'h080, 1'b1, 1'b1, 32'h080, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h084, 1'b0, 1'b0, 32'h084, 1'b1, 32'h200};
        tbl[9]  = '{32'h080, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1, 1'b1, 32'h200, 1'b0, 32'h004};
        tbl[10] = '{32'h180, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h184, 1'b0, 32'h004};
        tbl[11] = '{32'h080, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1, 1'b0, 32'h084, 1'b0, 32'h004};
        tbl[12] = '{32'h040, 1'b1, 1'b1, 32'h040, 1'b1, 1'b0, 1'b1, 32'h060, 1'b1, 32'h020, 1'b1, 1'b0, 32'h044, 1'b1, 32'h060};
        tbl[13] = '{32'h040, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h304, 1'b1, 1'b1, 32'h060, 1'b0, 32'h304};
        tbl[14] = '{32'h300, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h404, 1'b0, 1'b0, 32'h304, 1'b1, 32'h500};
        tbl[15] = '{32'h400, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h404, 1'b0, 32'h004};

        if_pc = 32'h0; if_valid = 1'b1;
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset asserted mid-cycle while an update is pending
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
        @(negedge clk);
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h40;
        #1 chk("pre_reset_hit", 32'(hit0), 32'd1);
        chk("pre_reset_br", br0, 32'd1);
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 32'h44);
        #1 rst = 1'b1;
        #1 chk("reset_hit", 32'(hit0), 32'd0);
        chk("reset_taken", 32'(tk0), 32'd0);
        chk("reset_br", br0, 32'd0);
        if_pc = 32'h100;
        #1 chk("reset_next", nx0, 32'h104);
        @(negedge clk);
        rst = 1'b0;
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h40;
        #2 chk("reset_no_partial_hit", 32'(hit0), 32'd0);
        chk("reset_no_partial_br", br0, 32'd0);
        @(negedge clk);

        // Directed table on the bimodal instance
        for (int i = 0; i < 16; i++) begin
            if_pc = tbl[i].if_pc; if_valid = tbl[i].if_valid;
            set_ex(tbl[i].upd, tbl[i].ex_pc, tbl[i].br, tbl[i].jal, tbl[i].tk,
                   tbl[i].tgt, tbl[i].ptk, tbl[i].pnx);
            #2;
            chk($sformatf("tbl%0d hit", i), 32'(hit0), 32'(tbl[i].e_hit));
            chk($sformatf("tbl%0d taken", i), 32'(tk0), 32'(tbl[i].e_tk));
            chk($sformatf("tbl%0d next", i), nx0, tbl[i].e_nx);
            chk($sformatf("tbl%0d mispredict", i), 32'(mis0), 32'(tbl[i].e_mis));
            chk($sformatf("tbl%0d redirect", i), rd0, tbl[i].e_rd);
            @(negedge clk);
        end
        chk("tbl br_count", br0, 32'd10);
        chk("tbl miss_count", ms0, 32'd6);

        // Gshare: alternating T/N at 0x40 becomes perfectly predicted
        do_reset();
        ghr_m = 32'd0;
        if_pc = 32'h40; if_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tk_g = ((k % 2) == 0);
            set_ex(1'b1, 32'h40, 1'b1, 1'b0, tk_g, 32'h20, 1'b0, 32'h44);
            #2;
            if (k >= 8) begin
                chk($sformatf("gshare%0d taken", k), 32'(tk1), 32'(tk_g));
                chk($sformatf("gshare%0d next", k), nx1, tk_g ? 32'h20 : 32'h44);
            end
            @(negedge clk);
            ghr_m = ((ghr_m << 1) | 32'(tk_g)) & 32'd3;
            chk($sformatf("gshare%0d ghr", k), 32'(dut1.r_ghr), ghr_m);
        end

        // Randomized run against the reference model, both indexing modes
        do_reset();
        m_reset();
        for (int c = 0; c < 800; c++) begin
            if_pc = rand_pc();
            if_valid = ($urandom_range(0, 7) != 0);
            kind = $urandom_range(0, 5);
            ex_update = ($urandom_range(0, 3) != 0);
            ex_pc = rand_pc();
            ex_is_branch = (kind < 4);
            ex_is_jal = (kind == 4);
            ex_taken = (kind < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
            ex_target = $urandom & 32'hFFFF_FFFC;
            ex_pred_taken = 1'($urandom_range(0, 1));
            ex_pred_next_pc = ($urandom_range(0, 1) != 0) ? ex_target : ex_pc + 32'd4;
            #2;
            m_lookup(0, hx, tx, nx);
            chk($sformatf("rnd%0d hit0", c), 32'(hit0), 32'(hx));
            chk($sformatf("rnd%0d taken0", c), 32'(tk0), 32'(tx));
            chk($sformatf("rnd%0d next0", c), nx0, nx);
            m_lookup(1, hx, tx, nx);
            chk($sformatf("rnd%0d hit1", c), 32'(hit1), 32'(hx));
            chk($sformatf("rnd%0d taken1", c), 32'(tk1), 32'(tx));
            chk($sformatf("rnd%0d next1", c), nx1, nx);
            mx = m_mispredict();
            chk($sformatf("rnd%0d mispredict", c), 32'({mis0, mis1}), 32'({mx, mx}));
            chk($sformatf("rnd%0d redirect0", c), rd0, ex_taken ? ex_target : ex_pc + 32'd4);
            chk($sformatf("rnd%0d redirect1", c), rd1, ex_taken ? ex_target : ex_pc + 32'd4);
            @(negedge clk);
            m_update();
        end
        chk("rnd br_count0", br0, m_br);
        chk("rnd miss_count0", ms0, m_miss);
        chk("rnd br_count1", br1, m_br);
        chk("rnd miss_count1", ms1, m_miss);

        // BR_COUNT wrap from a forced all-ones value
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        force dut0.r_br_count = 32'hFFFF_FFFF;
        #1 release dut0.r_br_count;
        #1 chk("wrap preload", br0, 32'hFFFF_FFFF);
        set_ex(1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 32'h500);
        @(negedge clk);
        ex_update = 1'b0;
        #1 chk("wrap br_count", br0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
